// File: rtl/xor_cipher_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : xor_cipher_fifo
//  Description : Parametrised encrypting FIFO. Words are XOR-ed with a key
//                that is rotated by the entry index on write. The same key
//                is applied again on read to restore the plaintext. A read
//                and a write can be accepted in the same cycle. Provides
//                occupancy count, almost-full and sticky overflow/underflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module xor_cipher_fifo #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 48,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int KEY_ROLL = 1,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              Cen,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              crypt_en,
  input  logic [DATA_W-1:0] Data_IN,
  input  logic [DATA_W-1:0] Cipher_Key,
  output logic [DATA_W-1:0] QUE_Data_Out,
  output logic              QUE_Valid,
  output logic              QUE_Empty,
  output logic              QUE_Last,
  output logic              QUE_Full,
  output logic              QUE_Almost_Full,
  output logic [CNT_W-1:0]  QUE_Count,
  output logic              QUE_Overflow,
  output logic              QUE_Underflow
);

  localparam int               PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);

  // Storage holds ciphertext (or plaintext for bypassed writes); never cleared.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              empty;
  logic              full;
  logic              rd_accept;
  logic              wr_accept;
  logic [PTR_W-1:0]  wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_next;
  logic [DATA_W-1:0] wr_key;
  logic [DATA_W-1:0] rd_key;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rd_word;

  // Per-entry key: base key rotated left by (entry index mod DATA_W).
  function automatic logic [DATA_W-1:0] entry_key(
    input logic [DATA_W-1:0] key,
    input logic [PTR_W-1:0]  p
  );
    logic [2*DATA_W-1:0] dbl;
    int unsigned         sh;
    if (KEY_ROLL == 0) begin
      return key;
    end
    sh  = 32'(p) % 32'(DATA_W);
    dbl = {key, key} << sh;
    return dbl[2*DATA_W-1 -: DATA_W];
  endfunction

  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);

  // A full queue still takes a write when a read frees a slot in the same
  // cycle; an empty queue never lets a write fall straight through to a read.
  assign rd_accept = Cen & rd_en & ~empty;
  assign wr_accept = Cen & wr_en & (~full | rd_accept);

  // Explicit wrap because DEPTH need not be a power of two.
  assign wr_ptr_next = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
  assign rd_ptr_next = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;

  assign wr_key  = entry_key(Cipher_Key, wr_ptr);
  assign rd_key  = entry_key(Cipher_Key, rd_ptr);
  assign wr_word = crypt_en ? (Data_IN ^ wr_key) : Data_IN;
  assign rd_word = crypt_en ? (mem[rd_ptr] ^ rd_key) : mem[rd_ptr];

  // Memory write port; reset blocks the write but leaves contents intact.
  always_ff @(posedge Clk) begin
    if (!reset && wr_accept) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  // Pointers, occupancy, registered read data and sticky error flags.
  always_ff @(posedge Clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      QUE_Data_Out  <= '0;
      QUE_Valid     <= 1'b0;
      QUE_Overflow  <= 1'b0;
      QUE_Underflow <= 1'b0;
    end else if (!Cen) begin
      QUE_Valid <= 1'b0;
    end else begin
      QUE_Valid <= rd_accept;
      if (rd_accept) begin
        QUE_Data_Out <= rd_word;
        rd_ptr       <= rd_ptr_next;
      end
      if (wr_accept) begin
        wr_ptr <= wr_ptr_next;
      end
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && !wr_accept) begin
        QUE_Overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        QUE_Underflow <= 1'b1;
      end
    end
  end

  assign QUE_Empty       = empty;
  assign QUE_Full        = full;
  assign QUE_Last        = (count == LAST_CNT);
  assign QUE_Almost_Full = (count >= AF_CNT);
  assign QUE_Count       = count;

endmodule
`default_nettype wire

// File: tb/tb_xor_cipher_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xor_cipher_fifo
//  Description : Directed bench for xor_cipher_fifo, 48-deep and 5-deep
//                instances, with a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xor_cipher_fifo;

  logic        clk;
  // 48-deep instance
  logic        reset, Cen, wr_en, rd_en, crypt_en;
  logic [31:0] Data_IN, Cipher_Key;
  logic [31:0] QUE_Data_Out;
  logic        QUE_Valid, QUE_Empty, QUE_Last, QUE_Full, QUE_Almost_Full;
  logic [5:0]  QUE_Count;
  logic        QUE_Overflow, QUE_Underflow;
  // 5-deep instance
  logic        s_reset, s_wr, s_rd;
  logic [31:0] s_data, s_key, s_out;
  logic        s_valid, s_empty, s_last, s_full, s_af, s_ovf, s_udf;
  logic [2:0]  s_count;

  int checks = 0;
  int errors = 0;

  // Reference model state for the 48-deep instance
  logic [31:0] q[$];
  int          mc;
  logic        m_ovf, m_udf;
  logic [31:0] m_last;

  xor_cipher_fifo u_dut (
    .Clk(clk), .reset(reset), .Cen(Cen), .wr_en(wr_en), .rd_en(rd_en),
    .crypt_en(crypt_en), .Data_IN(Data_IN), .Cipher_Key(Cipher_Key),
    .QUE_Data_Out(QUE_Data_Out), .QUE_Valid(QUE_Valid), .QUE_Empty(QUE_Empty),
    .QUE_Last(QUE_Last), .QUE_Full(QUE_Full), .QUE_Almost_Full(QUE_Almost_Full),
    .QUE_Count(QUE_Count), .QUE_Overflow(QUE_Overflow), .QUE_Underflow(QUE_Underflow)
  );

  xor_cipher_fifo #(.DEPTH(5)) u_small (
    .Clk(clk), .reset(s_reset), .Cen(1'b1), .wr_en(s_wr), .rd_en(s_rd),
    .crypt_en(1'b1), .Data_IN(s_data), .Cipher_Key(s_key),
    .QUE_Data_Out(s_out), .QUE_Valid(s_valid), .QUE_Empty(s_empty),
    .QUE_Last(s_last), .QUE_Full(s_full), .QUE_Almost_Full(s_af),
    .QUE_Count(s_count), .QUE_Overflow(s_ovf), .QUE_Underflow(s_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] k, input int n);
    logic [63:0] d;
    d = {k, k} << (n % 32);
    return d[63:32];
  endfunction

  // One clock of stimulus on the 48-deep instance; the model predicts the
  // outcome, then every output is compared just after the edge.
  task automatic cyc(input logic r, input logic ce, input logic w, input logic rd,
                     input logic cr, input logic [31:0] d);
    logic racc, wacc;
    reset = r; Cen = ce; wr_en = w; rd_en = rd; crypt_en = cr; Data_IN = d;
    racc = 1'b0;
    wacc = 1'b0;
    if (r) begin
      mc = 0; q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_last = '0;
    end else if (ce) begin
      racc = rd && (mc != 0);
      wacc = w && ((mc < 48) || racc);
      if (rd && mc == 0) m_udf = 1'b1;
      if (w && !wacc)    m_ovf = 1'b1;
      if (racc) m_last = q.pop_front();
      if (wacc) q.push_back(d);
      if (wacc && !racc) mc++;
      else if (racc && !wacc) mc--;
    end
    @(posedge clk);
    #1;
    chk("valid",     QUE_Valid,       racc);
    chk("data_out",  QUE_Data_Out,    m_last);
    chk("count",     QUE_Count,       mc);
    chk("empty",     QUE_Empty,       mc == 0);
    chk("full",      QUE_Full,        mc == 48);
    chk("last",      QUE_Last,        mc == 47);
    chk("almost",    QUE_Almost_Full, mc >= 44);
    chk("overflow",  QUE_Overflow,    m_ovf);
    chk("underflow", QUE_Underflow,   m_udf);
  endtask

  initial begin
    mc = 0; m_ovf = 0; m_udf = 0; m_last = 0;
    Cipher_Key = 32'hA5A5_5A5A;
    s_reset = 1'b1; s_wr = 1'b0; s_rd = 1'b0; s_data = '0; s_key = 32'h0F0F_00FF;

    // Reset state
    cyc(1, 1, 0, 0, 1, 0);
    cyc(1, 0, 1, 1, 1, 0);
    cyc(0, 1, 0, 0, 1, 0);

    // Fill with 1..48 encrypted
    for (int i = 1; i <= 48; i++) cyc(0, 1, 1, 0, 1, 32'(i));
    chk("mem0",  u_dut.mem[0],  32'hA5A5_5A5B);
    chk("mem1",  u_dut.mem[1],  32'd2  ^ rotl(Cipher_Key, 1));
    chk("mem33", u_dut.mem[33], 32'd34 ^ rotl(Cipher_Key, 33));
    chk("mem47", u_dut.mem[47], 32'd48 ^ rotl(Cipher_Key, 47));

    // Drain all 48 in order
    for (int i = 0; i < 48; i++) cyc(0, 1, 0, 1, 1, 0);

    // Read while empty, then simultaneous read+write while empty
    cyc(0, 1, 0, 1, 1, 0);
    cyc(0, 1, 1, 1, 1, 32'h0000_0100);

    // Refill to full, then three simultaneous read+write cycles
    for (int i = 1; i <= 47; i++) cyc(0, 1, 1, 0, 1, 32'h200 + 32'(i));
    for (int i = 0; i < 3; i++)   cyc(0, 1, 1, 1, 1, 32'h300 + 32'(i));

    // Write while full, sticky flags hold, chip disable holds everything
    cyc(0, 1, 1, 0, 1, 32'hDEAD_BEEF);
    cyc(0, 1, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 1, 32'h1111_1111);
    cyc(0, 1, 0, 0, 1, 0);

    // Reset mid-stream with a new key and bypassed words mixed in
    cyc(1, 1, 0, 0, 1, 0);
    Cipher_Key = 32'h1234_5678;
    for (int i = 1; i <= 10; i++)
      cyc((i == 6), 1, 1, 0, (i % 2 == 0), 32'h600 + 32'(i));
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 1, 32'h7777_0000);
    for (int i = 7; i <= 10; i++) cyc(0, 1, 0, 1, (i % 2 == 0), 0);
    cyc(0, 1, 0, 0, 1, 0);

    // 5-deep instance: alternating write/read pairs across pointer wrap
    @(posedge clk); #1;
    s_reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      s_wr = 1'b1; s_data = 32'hC000_0000 + 32'(i * 7);
      @(posedge clk); #1;
      s_wr = 1'b0;
      chk("s_count_w", s_count, 1);
      chk("s_wrptr",   u_small.wr_ptr, (i + 1) % 5);
      s_rd = 1'b1;
      @(posedge clk); #1;
      s_rd = 1'b0;
      chk("s_valid",   s_valid, 1);
      chk("s_data",    s_out, 32'hC000_0000 + 32'(i * 7));
      chk("s_count_r", s_count, 0);
      chk("s_rdptr",   u_small.rd_ptr, (i + 1) % 5);
    end
    chk("s_flags", {s_empty, s_last, s_full, s_af, s_ovf, s_udf}, 6'b100000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
